wb_result_arbiter: RTL and testbench

Writeback request arbiter feeding the execute-stage result mux. Collects completion requests from six execution sources plus a constant-result request from decode, grants one per cycle, and drives the mux's one-hot source select and zero/one/minus-one constant code. It also drives the destination GPR and tag into a registered writeback slot with valid/ready back-pressure toward the register file.

---
 rtl/wb_result_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_result_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_arbiter.sv
// Writeback result arbiter: picks one of six execution sources or the decode
// constant request each free cycle and registers the winner's mux select,
// constant code, destination GPR and tag into a single writeback slot.
module wb_result_arbiter #(
  parameter int TAG_W  = 4,
  parameter int GPR_AW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            src_valid,
  output logic [5:0]            src_ready,
  input  logic [6*GPR_AW-1:0]   src_gpr,
  input  logic [6*TAG_W-1:0]    src_tag,
  input  logic                  const_valid,
  output logic                  const_ready,
  input  logic [1:0]            const_kind,
  input  logic [GPR_AW-1:0]     const_gpr,
  input  logic [TAG_W-1:0]      const_tag,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [5:0]            wb_sel,
  output logic [2:0]            wb_zom,
  output logic [GPR_AW-1:0]     wb_gpr,
  output logic [TAG_W-1:0]      wb_tag
);

  localparam int NSRC       = 6;
  localparam int STREAK_MAX = 4;

  // Result-mux constant codes; ZOM_SRC means "take the source selected by wb_sel".
  typedef enum logic [2:0] {
    ZOM_SRC  = 3'b000,
    ZOM_ZERO = 3'b001,
    ZOM_ONE  = 3'b010,
    ZOM_MONE = 3'b100
  } zom_e;

  // Writeback slot and arbitration state.
  logic                wb_valid_q, wb_valid_d;
  logic [NSRC-1:0]     wb_sel_q,   wb_sel_d;
  logic [2:0]          wb_zom_q,   wb_zom_d;
  logic [GPR_AW-1:0]   wb_gpr_q,   wb_gpr_d;
  logic [TAG_W-1:0]    wb_tag_q,   wb_tag_d;
  logic [2:0]          rr_ptr_q,   rr_ptr_d;
  logic [2:0]          streak_q,   streak_d;

  // Arbitration intermediates.
  logic                slot_free;
  logic                src_any;
  logic                streak_full;
  logic                grant_en;
  logic                const_win;
  logic                src_win;
  logic                rr_hit;
  logic [2:0]          rr_idx;
  logic [GPR_AW-1:0]   win_gpr;
  logic [TAG_W-1:0]    win_tag;
  logic [2:0]          const_zom;

  assign slot_free   = !wb_valid_q || wb_ready;
  assign src_any     = |src_valid;
  assign streak_full = (streak_q == 3'(STREAK_MAX));
  // No grant is ever issued during reset, even though the slot counts as free.
  assign grant_en    = slot_free && !reset;
  // The constant request wins unless it has starved pending sources long enough.
  assign const_win   = grant_en && const_valid && !(streak_full && src_any);
  assign src_win     = grant_en && rr_hit && !const_win;

  // Round-robin search starting at rr_ptr_q; the first requesting source wins.
  always_comb begin : rr_search
    logic [2:0] cand;
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = 3'((int'(rr_ptr_q) + k) % NSRC);
      for (int i = 0; i < NSRC; i++) begin
        if (!rr_hit && (cand == 3'(i)) && src_valid[i]) begin
          rr_hit = 1'b1;
          rr_idx = 3'(i);
        end
      end
    end
  end

  // Payload mux for the round-robin winner.
  always_comb begin
    win_gpr = '0;
    win_tag = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (rr_idx == 3'(i)) begin
        win_gpr = src_gpr[i*GPR_AW +: GPR_AW];
        win_tag = src_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Constant kind decode; the reserved encoding behaves as zero.
  always_comb begin
    case (const_kind)
      2'b01:   const_zom = ZOM_ONE;
      2'b10:   const_zom = ZOM_MONE;
      default: const_zom = ZOM_ZERO;
    endcase
  end

  // Combinational grants back to the requesters.
  always_comb begin
    const_ready = const_win;
    src_ready   = src_win ? (NSRC'(1) << rr_idx) : '0;
  end

  // Next-state for the writeback slot, round-robin pointer and const streak.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_sel_d   = wb_sel_q;
    wb_zom_d   = wb_zom_q;
    wb_gpr_d   = wb_gpr_q;
    wb_tag_d   = wb_tag_q;
    rr_ptr_d   = rr_ptr_q;
    streak_d   = streak_q;

    if (slot_free) begin
      if (const_win) begin
        wb_valid_d = 1'b1;
        wb_sel_d   = '0;
        wb_zom_d   = const_zom;
        wb_gpr_d   = const_gpr;
        wb_tag_d   = const_tag;
        // Count only const grants that actually held off a waiting source.
        if (!src_any)         streak_d = '0;
        else if (!streak_full) streak_d = streak_q + 3'd1;
      end else if (src_win) begin
        wb_valid_d = 1'b1;
        wb_sel_d   = NSRC'(1) << rr_idx;
        wb_zom_d   = ZOM_SRC;
        wb_gpr_d   = win_gpr;
        wb_tag_d   = win_tag;
        rr_ptr_d   = (rr_idx == 3'(NSRC - 1)) ? 3'd0 : rr_idx + 3'd1;
        streak_d   = '0;
      end else begin
        // Free cycle with nothing to grant: the slot empties and clears.
        wb_valid_d = 1'b0;
        wb_sel_d   = '0;
        wb_zom_d   = ZOM_SRC;
        wb_gpr_d   = '0;
        wb_tag_d   = '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the payload registers are reset too, because the outputs are
      // required to read zero after reset, not merely be marked invalid.
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_zom_q   <= '0;
      wb_gpr_q   <= '0;
      wb_tag_q   <= '0;
      rr_ptr_q   <= '0;
      streak_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_zom_q   <= wb_zom_d;
      wb_gpr_q   <= wb_gpr_d;
      wb_tag_q   <= wb_tag_d;
      rr_ptr_q   <= rr_ptr_d;
      streak_q   <= streak_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_zom   = wb_zom_q;
  assign wb_gpr   = wb_gpr_q;
  assign wb_tag   = wb_tag_q;

  // Structural invariants of the grant and the writeback slot.
  a_one_grant: assert property (@(posedge clk) $onehot0({src_ready, const_ready}));
  a_sel_oh:    assert property (@(posedge clk) disable iff (reset) $onehot0(wb_sel_q));
  a_zom_oh:    assert property (@(posedge clk) disable iff (reset) $onehot0(wb_zom_q));
  a_slot_src:  assert property (@(posedge clk) disable iff (reset)
                 wb_valid_q |-> ((wb_sel_q != '0) != (wb_zom_q != 3'b000)));

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Self-checking bench for wb_result_arbiter: directed scenarios with a
// scoreboard of expected writeback slot contents.
module tb_wb_result_arbiter;

  localparam int TAG_W  = 4;
  localparam int GPR_AW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [5:0]          src_valid;
  logic [5:0]          src_ready;
  logic [6*GPR_AW-1:0] src_gpr;
  logic [6*TAG_W-1:0]  src_tag;
  logic                const_valid;
  logic                const_ready;
  logic [1:0]          const_kind;
  logic [GPR_AW-1:0]   const_gpr;
  logic [TAG_W-1:0]    const_tag;
  logic                wb_valid;
  logic                wb_ready;
  logic [5:0]          wb_sel;
  logic [2:0]          wb_zom;
  logic [GPR_AW-1:0]   wb_gpr;
  logic [TAG_W-1:0]    wb_tag;

  typedef struct packed {
    logic [5:0]        sel;
    logic [2:0]        zom;
    logic [GPR_AW-1:0] gpr;
    logic [TAG_W-1:0]  tag;
  } wb_exp_t;

  wb_exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_result_arbiter #(.TAG_W(TAG_W), .GPR_AW(GPR_AW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready), .src_gpr(src_gpr), .src_tag(src_tag),
    .const_valid(const_valid), .const_ready(const_ready), .const_kind(const_kind),
    .const_gpr(const_gpr), .const_tag(const_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_zom(wb_zom),
    .wb_gpr(wb_gpr), .wb_tag(wb_tag)
  );

  // Default payload of source i: gpr = i+8, tag = i+1.
  function automatic wb_exp_t src_exp(input int i);
    wb_exp_t e;
    e.sel = 6'b000001 << i;
    e.zom = 3'b000;
    e.gpr = GPR_AW'(i + 8);
    e.tag = TAG_W'(i + 1);
    return e;
  endfunction

  task automatic set_defaults();
    src_valid   = '0;
    const_valid = 1'b0;
    const_kind  = 2'b00;
    const_gpr   = '0;
    const_tag   = '0;
    wb_ready    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src_gpr[i*GPR_AW +: GPR_AW] = GPR_AW'(i + 8);
      src_tag[i*TAG_W +: TAG_W]   = TAG_W'(i + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_defaults();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_defaults();
    src_valid   = 6'b111111;
    const_valid = 1'b1;
    #1;
    checks++;
    if (src_ready !== 6'b0 || const_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: src_ready=%b const_ready=%b, expected 000000 0", src_ready, const_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected all zero",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag);
    end
    @(negedge clk);
    reset = 1'b0;
    set_defaults();
  endtask

  task automatic test_single_grant();
    wb_exp_t e;
    @(negedge clk);
    src_valid = 6'b000100;
    src_gpr[2*GPR_AW +: GPR_AW] = GPR_AW'(7);
    src_tag[2*TAG_W +: TAG_W]   = TAG_W'(3);
    #1;
    checks++;
    if (src_ready !== 6'b000100 || const_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: src_ready=%b const_ready=%b, expected 000100 0", src_ready, const_ready);
    end
    sb.push_back('{sel: 6'b000100, zom: 3'b000, gpr: GPR_AW'(7), tag: TAG_W'(3)});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL single_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    // Pointer should now sit at source 3: with everyone requesting, 3 wins.
    @(negedge clk);
    set_defaults();
    src_valid = 6'b111111;
    #1;
    checks++;
    if (src_ready !== 6'b001000) begin
      errors++;
      $display("FAIL rr_after_2: src_ready=%b, expected 001000", src_ready);
    end
    sb.push_back(src_exp(3));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL rr_after_2_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    // Free cycle with no request empties and clears the slot.
    @(negedge clk);
    src_valid = '0;
    #1;
    checks++;
    if (src_ready !== 6'b0 || const_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: src_ready=%b const_ready=%b, expected 000000 0", src_ready, const_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== '0) begin
      errors++;
      $display("FAIL idle_clear: v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected all zero",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag);
    end
  endtask

  task automatic test_round_robin();
    wb_exp_t    e;
    logic [5:0] exp_rdy;
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      src_valid = 6'b111111;
      exp_rdy   = 6'b000001 << (n % 6);
      #1;
      checks++;
      if (src_ready !== exp_rdy || const_ready !== 1'b0) begin
        errors++;
        $display("FAIL rr_ready[%0d]: src_ready=%b, expected %b", n, src_ready, exp_rdy);
      end
      sb.push_back(src_exp(n % 6));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
        errors++;
        $display("FAIL rr_wb[%0d]: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
                 n, wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
      end
    end
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic test_const_kinds();
    wb_exp_t    e;
    logic [2:0] zom_tbl [4];
    zom_tbl = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      src_valid   = '0;
      const_valid = 1'b1;
      const_kind  = 2'(k);
      const_gpr   = GPR_AW'(20 + k);
      const_tag   = TAG_W'(k + 4);
      #1;
      checks++;
      if (const_ready !== 1'b1 || src_ready !== 6'b0) begin
        errors++;
        $display("FAIL kind_ready[%0d]: const_ready=%b src_ready=%b, expected 1 000000", k, const_ready, src_ready);
      end
      sb.push_back('{sel: 6'b0, zom: zom_tbl[k], gpr: GPR_AW'(20 + k), tag: TAG_W'(k + 4)});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
        errors++;
        $display("FAIL kind_wb[%0d]: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
                 k, wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
      end
    end
    @(negedge clk);
    const_valid = 1'b0;
  endtask

  task automatic test_const_fairness();
    wb_exp_t e;
    logic    is_src [10];
    is_src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      const_valid = 1'b1;
      const_kind  = 2'b01;
      const_gpr   = GPR_AW'(17);
      const_tag   = TAG_W'(9);
      src_valid   = 6'b000010;
      #1;
      checks++;
      if (is_src[n]) begin
        if (src_ready !== 6'b000010 || const_ready !== 1'b0) begin
          errors++;
          $display("FAIL fair_ready[%0d]: src_ready=%b const_ready=%b, expected 000010 0", n, src_ready, const_ready);
        end
        sb.push_back(src_exp(1));
      end else begin
        if (src_ready !== 6'b0 || const_ready !== 1'b1) begin
          errors++;
          $display("FAIL fair_ready[%0d]: src_ready=%b const_ready=%b, expected 000000 1", n, src_ready, const_ready);
        end
        sb.push_back('{sel: 6'b0, zom: 3'b010, gpr: GPR_AW'(17), tag: TAG_W'(9)});
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
        errors++;
        $display("FAIL fair_wb[%0d]: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
                 n, wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
      end
    end
    @(negedge clk);
    set_defaults();
  endtask

  task automatic test_stall();
    wb_exp_t e;
    wb_exp_t held;
    held = src_exp(2);
    @(negedge clk);
    set_defaults();
    src_valid = 6'b000100;
    #1;
    checks++;
    if (src_ready !== 6'b000100) begin
      errors++;
      $display("FAIL stall_first_ready: src_ready=%b, expected 000100", src_ready);
    end
    sb.push_back(held);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_first_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      wb_ready  = 1'b0;
      src_valid = 6'b010000;
      #1;
      checks++;
      if (src_ready !== 6'b0 || const_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: src_ready=%b const_ready=%b, expected 000000 0", n, src_ready, const_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, held}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
                 n, wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, held.sel, held.zom, held.gpr, held.tag);
      end
    end
    @(negedge clk);
    wb_ready = 1'b1;
    #1;
    checks++;
    if (src_ready !== 6'b010000) begin
      errors++;
      $display("FAIL stall_release_ready: src_ready=%b, expected 010000", src_ready);
    end
    sb.push_back(src_exp(4));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_release_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic test_reset_mid();
    wb_exp_t e;
    @(negedge clk);
    set_defaults();
    src_valid = 6'b001000;
    #1;
    checks++;
    if (src_ready !== 6'b001000) begin
      errors++;
      $display("FAIL mid_pre_ready: src_ready=%b, expected 001000", src_ready);
    end
    sb.push_back(src_exp(3));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL mid_pre_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    @(negedge clk);
    reset       = 1'b1;
    src_valid   = 6'b111111;
    const_valid = 1'b1;
    #1;
    checks++;
    if (src_ready !== 6'b0 || const_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready: src_ready=%b const_ready=%b, expected 000000 0", src_ready, const_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected all zero",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag);
    end
    // Arbitration restarts from source 0.
    @(negedge clk);
    reset       = 1'b0;
    const_valid = 1'b0;
    #1;
    checks++;
    if (src_ready !== 6'b000001) begin
      errors++;
      $display("FAIL mid_restart_ready: src_ready=%b, expected 000001", src_ready);
    end
    sb.push_back(src_exp(0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL mid_restart_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    // Const against all six sources with a zero streak: const wins.
    @(negedge clk);
    const_valid = 1'b1;
    const_kind  = 2'b10;
    const_gpr   = GPR_AW'(30);
    const_tag   = TAG_W'(15);
    #1;
    checks++;
    if (const_ready !== 1'b1 || src_ready !== 6'b0) begin
      errors++;
      $display("FAIL tie_ready: const_ready=%b src_ready=%b, expected 1 000000", const_ready, src_ready);
    end
    sb.push_back('{sel: 6'b0, zom: 3'b100, gpr: GPR_AW'(30), tag: TAG_W'(15)});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag} !== {1'b1, e}) begin
      errors++;
      $display("FAIL tie_wb: got v=%b sel=%b zom=%b gpr=%0d tag=%0d, expected v=1 sel=%b zom=%b gpr=%0d tag=%0d",
               wb_valid, wb_sel, wb_zom, wb_gpr, wb_tag, e.sel, e.zom, e.gpr, e.tag);
    end
    @(negedge clk);
    set_defaults();
  endtask

  initial begin
    reset = 1'b1;
    set_defaults();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_const_kinds();
    test_const_fairness();
    test_stall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
